// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode values, sequencer state encoding and opcode check for alu_seq_ctrl.
package alu_seq_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        RESP
    } state_t;

    // True for the opcodes the ALU implements; anything else is flagged as bad data.
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command stream, ALU drive/return and result handshake bundle for alu_seq_ctrl.
interface alu_seq_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   alu_in1;
    logic [WIDTH-1:0]   alu_in2;
    logic [3:0]         alu_op;
    logic               alu_nvalid_data;
    logic [2*WIDTH-1:0] alu_out;
    logic               alu_zero;
    logic               alu_error;
    logic [2*WIDTH-1:0] res_data;
    logic               res_zero;
    logic               res_error;
    logic               res_valid;
    logic               res_ready;

    // Sequencer side
    modport slave (
        input  in_data, in_valid, alu_out, alu_zero, alu_error, res_ready,
        output in_ready, alu_in1, alu_in2, alu_op, alu_nvalid_data,
               res_data, res_zero, res_error, res_valid
    );

    // Environment side: command source, ALU and result consumer
    modport master (
        output in_data, in_valid, alu_out, alu_zero, alu_error, res_ready,
        input  in_ready, alu_in1, alu_in2, alu_op, alu_nvalid_data,
               res_data, res_zero, res_error, res_valid
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Byte-serial operand sequencer and result register in front of the combinational ALU.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_ctrl_if.slave    bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_xfer;

    logic [3:0]         r_op;
    logic               r_bad;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_res_data;
    logic               r_res_zero;
    logic               r_res_error;
    logic               r_res_valid;
    logic [CNT_W-1:0]   r_op_count;
    logic [CNT_W-1:0]   r_err_count;

    assign w_xfer = bus.in_valid && w_in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = GET_A;
            end
            GET_A: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = GET_B;
            end
            GET_B: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_next = EXEC;
            end
            EXEC: w_next = RESP;
            RESP: if (bus.res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latches, result capture and status counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= '0;
            r_bad       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_error <= 1'b0;
            r_res_valid <= 1'b0;
            r_op_count  <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_op  <= bus.in_data[3:0];
                        r_bad <= !is_valid_op(bus.in_data[3:0]);
                    end
                end
                GET_A: if (w_xfer) r_a <= bus.in_data;
                GET_B: if (w_xfer) r_b <= bus.in_data;
                EXEC: begin
                    r_res_data  <= bus.alu_out;
                    r_res_zero  <= bus.alu_zero;
                    r_res_error <= bus.alu_error;
                    r_res_valid <= 1'b1;
                    r_op_count  <= r_op_count + 1'b1;
                    if (bus.alu_error && (r_err_count != '1)) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                end
                RESP: if (bus.res_ready) r_res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.alu_in1         = r_a;
    assign bus.alu_in2         = r_b;
    assign bus.alu_op          = r_op;
    assign bus.alu_nvalid_data = r_bad;
    assign bus.res_data        = r_res_data;
    assign bus.res_zero        = r_res_zero;
    assign bus.res_error       = r_res_error;
    assign bus.res_valid       = r_res_valid;
    assign busy                = (r_state != IDLE);
    assign op_count            = r_op_count;
    assign err_count           = r_err_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural signed ALU attached.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] op_count;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    alu_seq_ctrl_if #(.WIDTH(8)) bus ();

    alu_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .op_count  (op_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: signed 8x8 -> 16, all-ones + error on bad data or divide by zero
    logic signed [15:0] ea, eb, er;
    always_comb begin
        ea            = 16'($signed(bus.alu_in1));
        eb            = 16'($signed(bus.alu_in2));
        er            = '0;
        bus.alu_error = 1'b0;
        if (bus.alu_nvalid_data) begin
            er            = '1;
            bus.alu_error = 1'b1;
        end else begin
            case (bus.alu_op)
                4'd0: er = ea + eb;
                4'd2: er = ea - eb;
                4'd4: er = ea * eb;
                4'd8: begin
                    if (eb == 0) begin
                        er            = '1;
                        bus.alu_error = 1'b1;
                    end else begin
                        er = ea / eb;
                    end
                end
                default: begin
                    er            = '1;
                    bus.alu_error = 1'b1;
                end
            endcase
        end
        bus.alu_out  = er;
        bus.alu_zero = !bus.alu_error && (er == 0);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++;
        failures++;
        $display("FAIL send_byte_timeout byte=%02h in_ready stayed 0, required 1", b);
        bus.in_valid = 1'b0;
    endtask

    // Drives one command and observes the result; callers do the comparisons.
    task automatic run_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gap, input bit consume,
                           output logic [15:0] d, output logic z, output logic e,
                           output logic nv, output int lat);
        send_byte(op, gap);
        send_byte(a, gap);
        send_byte(b, gap);
        nv  = bus.alu_nvalid_data;
        lat = 0;
        while (!bus.res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.res_data;
        z = bus.res_zero;
        e = bus.res_error;
        if (consume) begin
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl in_ready=%b busy=%b res_valid=%b required 1 0 0",
                     bus.in_ready, busy, bus.res_valid);
        end
        checks++;
        if (bus.alu_in1 !== 8'h00 || bus.alu_in2 !== 8'h00 || bus.alu_op !== 4'h0 ||
            bus.alu_nvalid_data !== 1'b0 || bus.res_data !== 16'h0000 ||
            op_count !== 8'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_regs in1=%h in2=%h op=%h nv=%b res=%h opc=%0d errc=%0d required all 0",
                     bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_nvalid_data,
                     bus.res_data, op_count, err_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [15:0] d; logic z, e, nv; int lat;
        run_cmd(8'h00, 8'h05, 8'h03, 0, 1'b0, d, z, e, nv, lat);
        checks++;
        if (d !== 16'h0008 || z !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL add_5_3 data=%h z=%b e=%b required 0008 0 0", d, z, e);
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL add_latency cycles=%0d required 1", lat);
        end
        checks++;
        if (op_count !== 8'd1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_status opc=%0d busy=%b in_ready=%b required 1 1 0",
                     op_count, busy, bus.in_ready);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.res_data !== 16'h0008) begin
            failures++;
            $display("FAIL add_consume res_valid=%b busy=%b data=%h required 0 0 0008",
                     bus.res_valid, busy, bus.res_data);
        end
        run_cmd(8'h02, 8'h03, 8'h05, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'hFFFE || e !== 1'b0) begin
            failures++;
            $display("FAIL sub_3_5 data=%h e=%b required fffe 0", d, e);
        end
        run_cmd(8'h04, 8'hFC, 8'h03, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'hFFF4 || e !== 1'b0) begin
            failures++;
            $display("FAIL mul_m4_3 data=%h e=%b required fff4 0", d, e);
        end
    endtask

    task automatic test_errors();
        logic [15:0] d; logic z, e, nv; int lat;
        run_cmd(8'h08, 8'h07, 8'h00, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'hFFFF || e !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL div_by_zero data=%h e=%b errc=%0d required ffff 1 1", d, e, err_count);
        end
        run_cmd(8'h01, 8'h02, 8'h02, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (nv !== 1'b1 || d !== 16'hFFFF || e !== 1'b1 || z !== 1'b0 || err_count !== 8'd2) begin
            failures++;
            $display("FAIL bad_opcode nv=%b data=%h e=%b z=%b errc=%0d required 1 ffff 1 0 2",
                     nv, d, e, z, err_count);
        end
        run_cmd(8'h00, 8'h00, 8'h00, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'h0000 || z !== 1'b1 || e !== 1'b0 || op_count !== 8'd6) begin
            failures++;
            $display("FAIL add_zero data=%h z=%b e=%b opc=%0d required 0000 1 0 6",
                     d, z, e, op_count);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d; logic z, e, nv; int lat;
        run_cmd(8'h00, 8'h10, 8'h20, 0, 1'b0, d, z, e, nv, lat);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 ||
                bus.res_data !== 16'h0030 || op_count !== 8'd7) begin
                failures++;
                $display("FAIL hold_cycle_%0d in_ready=%b res_valid=%b data=%h opc=%0d required 0 1 0030 7",
                         i, bus.in_ready, bus.res_valid, bus.res_data, op_count);
            end
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.res_data !== 16'h0030) begin
            failures++;
            $display("FAIL release res_valid=%b busy=%b data=%h required 0 0 0030",
                     bus.res_valid, busy, bus.res_data);
        end
        run_cmd(8'h02, 8'h10, 8'h20, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'hFFF0 || op_count !== 8'd8) begin
            failures++;
            $display("FAIL after_release data=%h opc=%0d required fff0 8", d, op_count);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] d; logic z, e, nv; int lat;
        run_cmd(8'h04, 8'hFC, 8'h03, 3, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'hFFF4 || e !== 1'b0 || lat !== 1) begin
            failures++;
            $display("FAIL gap_mul data=%h e=%b lat=%0d required fff4 0 1", d, e, lat);
        end
        run_cmd(8'h00, 8'h05, 8'h03, 2, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'h0008 || z !== 1'b0) begin
            failures++;
            $display("FAIL gap_add data=%h z=%b required 0008 0", d, z);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] d; logic z, e, nv; int lat;
        send_byte(8'h04, 0);
        send_byte(8'h07, 0);
        checks++;
        if (busy !== 1'b1 || bus.alu_in1 !== 8'h07 || bus.alu_op !== 4'h4) begin
            failures++;
            $display("FAIL pre_reset busy=%b in1=%h op=%h required 1 07 4", busy, bus.alu_in1, bus.alu_op);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.alu_in1 !== 8'h00 ||
            bus.alu_op !== 4'h0 || bus.res_data !== 16'h0000 ||
            op_count !== 8'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset in_ready=%b busy=%b in1=%h op=%h res=%h opc=%0d errc=%0d required 1 0 00 0 0000 0 0",
                     bus.in_ready, busy, bus.alu_in1, bus.alu_op, bus.res_data, op_count, err_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_cmd(8'h00, 8'h01, 8'h01, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (d !== 16'h0002 || op_count !== 8'd1) begin
            failures++;
            $display("FAIL post_reset_add data=%h opc=%0d required 0002 1", d, op_count);
        end
    endtask

    task automatic test_counters();
        logic [15:0] d; logic z, e, nv; int lat;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_cmd(8'h08, 8'h01, 8'h00, 0, 1'b1, d, z, e, nv, lat);
        end
        checks++;
        if (op_count !== 8'd0 || err_count !== 8'hFF) begin
            failures++;
            $display("FAIL count_256 opc=%0d errc=%0d required 0 255", op_count, err_count);
        end
        run_cmd(8'h08, 8'h01, 8'h00, 0, 1'b1, d, z, e, nv, lat);
        checks++;
        if (op_count !== 8'd1 || err_count !== 8'hFF || e !== 1'b1) begin
            failures++;
            $display("FAIL count_257 opc=%0d errc=%0d e=%b required 1 255 1", op_count, err_count, e);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.res_ready = 1'b0;
        test_reset();
        test_arith();
        test_errors();
        test_backpressure();
        test_gaps();
        test_reset_mid_op();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Operand sequencer and result register for the team's combinational signed ALU.
- Upstream, it accepts a byte-serial command stream (opcode, operand A, operand B) over a valid/ready handshake, holds the ALU inputs stable, and captures the ALU outputs in one execute cycle.
- Downstream, it presents the registered result on a valid/ready handshake.
- It keeps operation and error counters for status.

Parameters:
WIDTH, 8, operand width; ALU result width is 2*WIDTH.
CNT_W, 8, width of the op and error counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_data  in  WIDTH  command word: opcode (low 4 bits) or operand
in_valid  in  1  in_data valid
in_ready  out  1  block can accept in_data
alu_in1  out  WIDTH  signed operand A to ALU
alu_in2  out  WIDTH  signed operand B to ALU
alu_op  out  4  opcode to ALU
alu_nvalid_data  out  1  forces ALU error output
alu_out  in  2*WIDTH  signed ALU result
alu_zero  in  1  ALU zero flag
alu_error  in  1  ALU error flag
res_data  out  2*WIDTH  registered result
res_zero  out  1  registered zero flag
res_error  out  1  registered error flag
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
busy  out  1  high whenever state != IDLE
op_count  out  CNT_W  completed operations, wraps
err_count  out  CNT_W  errored operations, saturates

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0 except in_ready=1; this includes alu_* drives, res_*, both counters and busy.
- Input transfer occurs on a clock edge with in_valid && in_ready. in_ready=1 only in IDLE, GET_A and GET_B.
- FSM:
  - IDLE: transfer -> latch op=in_data[3:0]; op_bad=1 unless op is ADD(0), SUB(2), MUL(4) or DIV(8); -> GET_A.
  - GET_A: transfer -> latch A -> GET_B.
  - GET_B: transfer -> latch B -> EXEC.
  - EXEC (exactly 1 cycle): ALU inputs are stable; at the edge, capture alu_out/alu_zero/alu_error into res_*; res_valid<=1; op_count++; if alu_error, err_count++ (saturating at all-ones) -> RESP.
  - RESP: hold res_* stable while res_valid=1. On res_ready=1: res_valid<=0 -> IDLE. res_ready is ignored when res_valid=0.
- No transfer means stay in state; inputs are never dropped or duplicated.
- alu_in1, alu_in2, alu_op and alu_nvalid_data are registered copies of latched A, B, op and op_bad. They change only at transfer edges and are stable through EXEC.
- alu_nvalid_data=op_bad. An unsupported opcode still consumes A and B. The result is ALU-defined: all-ones data, error=1, zero=0.
- DIV by 0 is handled by the ALU: res_data=all-ones, res_error=1.
- Latency: B accepted at edge N -> EXEC during cycle N+1 -> res_valid=1 after edge N+1. Minimum command period is 5 cycles (3 input, EXEC, RESP with res_ready=1).
- in_valid is ignored in EXEC and RESP (in_ready=0). No new command starts until the result is consumed.
- res_data, res_zero and res_error retain their last value after consumption until the next EXEC.
- op_count wraps modulo 2^CNT_W. err_count saturates.
- Reset mid-operation in any state returns to IDLE immediately. Partial commands are discarded, counters clear, and any pending result is lost.

Decomposition:
- Shared include/package alu_defs: opcode localparams OP_ADD=0, OP_SUB=2, OP_MUL=4, OP_DIV=8; FSM state encodings IDLE/GET_A/GET_B/EXEC/RESP; an is_valid_op function.
- The ALU itself stays a separate existing module. A wrapper alu_unit (alu_seq_ctrl + alu) is natural for top-level integration and benches.
- No sub-module inside alu_seq_ctrl.

Test Plan:
- Reset, then stream 0x00, 0x05, 0x03 with res_ready=1 -> res_data=16'h0008, zero=0, error=0; res_valid one cycle after EXEC; op_count=1.
- SUB: stream 0x02, 0x03, 0x05 -> res_data=16'hFFFE, error=0. MUL: stream 0x04, 0xFC, 0x03 -> res_data=16'hFFF4.
- Error cases:
  - DIV by zero: stream 0x08, 0x07, 0x00 -> res_data=16'hFFFF, error=1, err_count=1.
  - Bad opcode: stream 0x01, 0x02, 0x02 -> alu_nvalid_data=1 through EXEC, res_data=16'hFFFF, error=1, err_count=2.
  - ADD with 0x00, 0x00 -> zero=1.
- Backpressure:
  - Hold res_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, res_* stable, no extra commands accepted.
  - Release res_ready -> one result consumed, next command then accepted.
  - in_valid gaps between bytes -> identical results.
- Reset mid-op: assert rst in GET_B -> outputs at reset values immediately. A following full ADD 1+1 -> res_data=2, op_count=1.
- Counters: 2^CNT_W+1 ops, all DIV by 0 -> op_count=1 (wrapped), err_count=all-ones (saturated).
